// File: rtl/mat_add_host_master.sv
// Avalon-MM master for the matrix-add slave: loads A then B as 32-bit half writes, triggers, reads C back out.
// Load is 2 cycles/word, readout 1 word/cycle; stalls on in_valid gaps, avm_waitrequest and out_ready.
module mat_add_host_master #(
   parameter int N_WORDS    = 256,
   parameter int B_BASE     = 256,
   parameter int START_ADDR = 512,
   parameter int ADDR_W     = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_start,
   output logic              cmd_busy,
   output logic              cmd_done,
   input  logic [63:0]       in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [63:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] avm_address,
   output logic [63:0]       avm_writedata,
   output logic              avm_write,
   output logic              avm_read,
   output logic [7:0]        avm_byteenable,
   input  logic [63:0]       avm_readdata,
   input  logic              avm_waitrequest
);
   typedef enum logic [2:0] {IDLE, LD_LO, LD_HI, TRIG, RD, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] L_N     = ADDR_W'(N_WORDS);
   localparam logic [ADDR_W-1:0] L_WLAST = ADDR_W'(2*N_WORDS-1);
   localparam logic [ADDR_W-1:0] L_BBASE = ADDR_W'(B_BASE);
   localparam logic [ADDR_W-1:0] L_START = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-2:0] L_RLAST = (ADDR_W-1)'(N_WORDS-1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_wcnt;
   logic [ADDR_W-2:0] r_rcnt;
   logic [63:0]       r_hold;
   logic              r_last;
   logic              r_rd_stall;
   logic              r_cmd_busy;
   logic              r_cmd_done;
   logic              r_out_valid;
   logic [63:0]       r_out_data;
   logic              r_avm_write;
   logic [ADDR_W-1:0] r_avm_address;
   logic [63:0]       r_avm_writedata;
   logic [7:0]        r_avm_byteenable;

   logic              w_wr_stall;
   logic              w_in_ready;
   logic              w_out_fire;
   logic              w_avm_read;
   logic              w_rd_done;
   logic [ADDR_W-1:0] w_wr_addr;

   // The high-half write of word k is still on the bus while word k+1 is accepted.
   assign w_wr_stall = r_avm_write && avm_waitrequest;
   assign w_in_ready = (r_state == LD_LO) && !w_wr_stall && !r_last;
   assign w_out_fire = r_out_valid && out_ready;
   // Once a read has been stalled it stays asserted; the output register is necessarily empty by then.
   assign w_avm_read = (r_state == RD) && (r_rd_stall || !r_out_valid || out_ready);
   assign w_rd_done  = w_avm_read && !avm_waitrequest;
   assign w_wr_addr  = (r_wcnt < L_N) ? r_wcnt : (L_BBASE + r_wcnt - L_N);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= IDLE;
         r_wcnt           <= '0;
         r_rcnt           <= '0;
         r_hold           <= '0;
         r_last           <= 1'b0;
         r_rd_stall       <= 1'b0;
         r_cmd_busy       <= 1'b0;
         r_cmd_done       <= 1'b0;
         r_out_valid      <= 1'b0;
         r_out_data       <= '0;
         r_avm_write      <= 1'b0;
         r_avm_address    <= '0;
         r_avm_writedata  <= '0;
         r_avm_byteenable <= '0;
      end else begin
         r_cmd_done <= 1'b0;
         r_rd_stall <= w_avm_read && avm_waitrequest;
         if (w_out_fire)
            r_out_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cmd_start && !r_cmd_done) begin
                  r_cmd_busy <= 1'b1;
                  r_wcnt     <= '0;
                  r_last     <= 1'b0;
                  r_state    <= LD_LO;
               end
            end
            LD_LO: begin
               if (!w_wr_stall) begin
                  if (r_last) begin
                     r_avm_write      <= 1'b1;
                     r_avm_address    <= L_START;
                     r_avm_writedata  <= '0;
                     r_avm_byteenable <= 8'hFF;
                     r_last           <= 1'b0;
                     r_state          <= TRIG;
                  end else if (in_valid) begin
                     r_hold           <= in_data;
                     r_avm_write      <= 1'b1;
                     r_avm_address    <= w_wr_addr;
                     r_avm_writedata  <= {32'b0, in_data[31:0]};
                     r_avm_byteenable <= 8'h0F;
                     r_state          <= LD_HI;
                  end else begin
                     r_avm_write <= 1'b0;
                  end
               end
            end
            LD_HI: begin
               if (!avm_waitrequest) begin
                  r_avm_writedata  <= {r_hold[63:32], 32'b0};
                  r_avm_byteenable <= 8'hF0;
                  r_state          <= LD_LO;
                  if (r_wcnt == L_WLAST)
                     r_last <= 1'b1;
                  else
                     r_wcnt <= r_wcnt + 1'b1;
               end
            end
            TRIG: begin
               if (!avm_waitrequest) begin
                  r_avm_write      <= 1'b0;
                  r_avm_address    <= '0;
                  r_avm_writedata  <= '0;
                  r_avm_byteenable <= 8'hFF;
                  r_rcnt           <= '0;
                  r_state          <= RD;
               end
            end
            RD: begin
               if (w_rd_done) begin
                  r_out_data  <= avm_readdata;
                  r_out_valid <= 1'b1;
                  if (r_rcnt == L_RLAST) begin
                     r_state <= DRAIN;
                  end else begin
                     r_rcnt        <= r_rcnt + 1'b1;
                     r_avm_address <= {1'b0, r_rcnt + 1'b1};
                  end
               end
            end
            DRAIN: begin
               if (w_out_fire) begin
                  r_cmd_busy <= 1'b0;
                  r_cmd_done <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_busy       = r_cmd_busy;
   assign cmd_done       = r_cmd_done;
   assign in_ready       = w_in_ready;
   assign out_data       = r_out_data;
   assign out_valid      = r_out_valid;
   assign avm_address    = r_avm_address;
   assign avm_writedata  = r_avm_writedata;
   assign avm_write      = r_avm_write;
   assign avm_read       = w_avm_read;
   assign avm_byteenable = r_avm_byteenable;
endmodule
